// File: rtl/dma_reg_arbiter_pkg.sv
// Shared types and constants for the DMA register-bus arbiter.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int RD_LAT_MAX = 4;
  localparam int LAT_CW     = $clog2(RD_LAT_MAX);

  // Width of a binary channel index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dma_reg_arbiter_if.sv
// Channel handshake and register-bus signals of the arbiter.
// master: the arbiter (drives the register bus, answers the channels).
// slave:  the environment (channel controllers and register-bus slave).
interface dma_reg_arbiter_if #(
  parameter int NCH = 4,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH-1:0]    ch_wr;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_rsp_valid;
  logic [DW-1:0]     ch_rdata;
  logic              wr_en;
  logic              rd_en;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;

  modport master (
    input  ch_valid, ch_wr, ch_addr, ch_wdata, rdata,
    output ch_ready, ch_rsp_valid, ch_rdata, wr_en, rd_en, addr, wdata
  );

  modport slave (
    output ch_valid, ch_wr, ch_addr, ch_wdata, rdata,
    input  ch_ready, ch_rsp_valid, ch_rdata, wr_en, rd_en, addr, wdata
  );
endinterface

// File: rtl/dma_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr,
// wrapping modulo NCH. Works for non-power-of-two NCH.
module dma_rr_pick
  import dma_arb_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [idx_w(NCH)-1:0]  ptr,
  output logic [NCH-1:0]         gnt,
  output logic [idx_w(NCH)-1:0]  idx
);
  localparam int IW = idx_w(NCH);

  logic [IW:0] d;
  logic [IW:0] best_d;

  // Pick the requester with the smallest rotational distance from ptr.
  always_comb begin
    idx    = '0;
    d      = '0;
    best_d = '1;
    for (int j = 0; j < NCH; j++) begin
      if (IW'(j) >= ptr) d = {1'b0, IW'(j)} - {1'b0, ptr};
      else               d = {1'b0, IW'(j)} + (IW+1)'(NCH) - {1'b0, ptr};
      if (req[j] && (d < best_d)) begin
        best_d = d;
        idx    = IW'(j);
      end
    end
    gnt = (req != '0) ? (NCH'(1) << idx) : '0;
  end

endmodule

// File: rtl/dma_reg_arbiter.sv
// N-channel arbiter sharing one register bus, one transaction in flight.
// Build option: DMA_ARB_PRIO_EN gives channel 0 strict priority over the
// round-robin channels; undefined means pure round-robin.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch happen here
// ISSUE | single-cycle wr_en or rd_en on the bus
// WAIT  | counting out the slave read latency
// RESP  | one-cycle ch_rsp_valid to the granted channel
module dma_reg_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  dma_reg_arbiter_if.master bus
);
  localparam int IW = idx_w(NCH);

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [IW-1:0]     gnt_idx, gnt_idx_nxt;
  logic [LAT_CW-1:0] lat_cnt, lat_cnt_nxt;
  logic              wr_en_q, wr_en_nxt;
  logic              rd_en_q, rd_en_nxt;
  logic [AW-1:0]     addr_q, addr_nxt;
  logic [DW-1:0]     wdata_q, wdata_nxt;
  logic [DW-1:0]     rdata_q, rdata_nxt;
  logic [NCH-1:0]    rsp_q, rsp_nxt;
  logic [NCH-1:0]    ready_c;

  logic [NCH-1:0]    pick_req, pick_gnt, sel_gnt;
  logic [IW-1:0]     pick_idx, sel_idx;
  logic              ptr_hold;

  logic [AW-1:0]     addr_arr  [NCH];
  logic [DW-1:0]     wdata_arr [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign addr_arr[i]  = bus.ch_addr[i*AW +: AW];
    assign wdata_arr[i] = bus.ch_wdata[i*DW +: DW];
  end

`ifdef DMA_ARB_PRIO_EN
  // Channel 0 bypasses the rotation and leaves the pointer alone.
  assign pick_req = {bus.ch_valid[NCH-1:1], 1'b0};
  assign sel_gnt  = bus.ch_valid[0] ? NCH'(1) : pick_gnt;
  assign sel_idx  = bus.ch_valid[0] ? '0 : pick_idx;
  assign ptr_hold = bus.ch_valid[0];
`else
  assign pick_req = bus.ch_valid;
  assign sel_gnt  = pick_gnt;
  assign sel_idx  = pick_idx;
  assign ptr_hold = 1'b0;
`endif

  dma_rr_pick #(.NCH(NCH)) u_pick (
    .req (pick_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Next-state and next-register values; ch_ready is the only comb output.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_idx_nxt = gnt_idx;
    lat_cnt_nxt = lat_cnt;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rdata_nxt   = rdata_q;
    rsp_nxt     = '0;
    ready_c     = '0;
    case (state)
      IDLE: begin
        if (sel_gnt != '0) begin
          ready_c     = sel_gnt;
          gnt_idx_nxt = sel_idx;
          addr_nxt    = addr_arr[sel_idx];
          wr_en_nxt   = bus.ch_wr[sel_idx];
          rd_en_nxt   = ~bus.ch_wr[sel_idx];
          wdata_nxt   = bus.ch_wr[sel_idx] ? wdata_arr[sel_idx] : '0;
          if (!ptr_hold)
            ptr_nxt = (sel_idx == IW'(NCH-1)) ? '0 : sel_idx + IW'(1);
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        // wr_en_q still holds the transaction type during this cycle.
        if (wr_en_q) begin
          rsp_nxt   = NCH'(1) << gnt_idx;
          state_nxt = RESP;
        end else if (RD_LAT == 1) begin
          rdata_nxt = bus.rdata;
          rsp_nxt   = NCH'(1) << gnt_idx;
          state_nxt = RESP;
        end else begin
          lat_cnt_nxt = LAT_CW'(RD_LAT-1);
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        // Terminal count: this decrement reaches zero, so rdata is valid now.
        if (lat_cnt == LAT_CW'(1)) begin
          lat_cnt_nxt = '0;
          rdata_nxt   = bus.rdata;
          rsp_nxt     = NCH'(1) << gnt_idx;
          state_nxt   = RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      lat_cnt <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= gnt_idx_nxt;
      lat_cnt <= lat_cnt_nxt;
      wr_en_q <= wr_en_nxt;
      rd_en_q <= rd_en_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
      rsp_q   <= rsp_nxt;
    end
  end

  assign bus.ch_ready     = ready_c;
  assign bus.ch_rsp_valid = rsp_q;
  assign bus.ch_rdata     = rdata_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.addr         = addr_q;
  assign bus.wdata        = wdata_q;

endmodule

// File: tb/tb_dma_reg_arbiter.sv
// Directed bench for dma_reg_arbiter (NCH=4, RD_LAT=3). The priority
// scenario expects channel-0 priority when DMA_ARB_PRIO_EN is defined.
module tb_dma_reg_arbiter;
  localparam int NCH    = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;
  localparam logic [31:0] RD_IDLE = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  valid = 4'b0000;
  logic [3:0]  wr    = 4'b0000;
  logic [31:0] a_arr [4];
  logic [31:0] d_arr [4];

  int n_chk  = 0;
  int n_pass = 0;
  int rsp_tot [4];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int strobe_viol = 0;
  logic prev_strobe = 1'b0;

  dma_reg_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

  assign bus.ch_valid = valid;
  assign bus.ch_wr    = wr;
  assign bus.ch_addr  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign bus.ch_wdata = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

  dma_reg_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Bus and response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_strobe <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.ch_rsp_valid[i]) rsp_tot[i] <= rsp_tot[i] + 1;
      if (bus.rd_en) rd_cnt <= rd_cnt + 1;
      if (bus.wr_en) wr_cnt <= wr_cnt + 1;
      if (prev_strobe && (bus.wr_en || bus.rd_en)) strobe_viol <= strobe_viol + 1;
      prev_strobe <= bus.wr_en | bus.rd_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int n = 0;
    int k = -2;
    for (int i = 0; i < 4; i++) if (v[i]) begin n++; k = i; end
    return (n == 1) ? k : -2;
  endfunction

  // Returns the granted channel in its accept cycle, or -1 after 20 cycles.
  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.ch_ready != 4'b0000) begin
        g = onehot_idx(bus.ch_ready);
        return;
      end
      step();
    end
  endtask

  function automatic int rsp_sum();
    return rsp_tot[0] + rsp_tot[1] + rsp_tot[2] + rsp_tot[3];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({bus.wr_en, bus.rd_en} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {bus.wr_en, bus.rd_en}); else n_pass++;
    n_chk++; if (bus.addr !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.addr); else n_pass++;
    n_chk++; if (bus.wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", bus.wdata); else n_pass++;
    n_chk++; if (bus.ch_rsp_valid !== 4'b0000) $display("FAIL reset_rsp got %b want 0000", bus.ch_rsp_valid); else n_pass++;
    n_chk++; if (bus.ch_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.ch_rdata); else n_pass++;
    n_chk++; if (bus.ch_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.ch_ready); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    int g;
    int rd0 = rd_cnt;
    a_arr[2] = 32'h10; d_arr[2] = 32'hDEADBEEF; wr = 4'b0100; valid = 4'b0100;
    wait_grant(g);
    n_chk++; if (g !== 2) $display("FAIL wr_grant got %0d want 2", g); else n_pass++;
    step(); valid = 4'b0000;
    n_chk++; if ({bus.wr_en, bus.rd_en} !== 2'b10) $display("FAIL wr_strobe got %b want 10", {bus.wr_en, bus.rd_en}); else n_pass++;
    n_chk++; if (bus.addr !== 32'h10) $display("FAIL wr_addr got %h want 10", bus.addr); else n_pass++;
    n_chk++; if (bus.wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata got %h want deadbeef", bus.wdata); else n_pass++;
    n_chk++; if (bus.ch_rsp_valid !== 4'b0000) $display("FAIL wr_rsp_early got %b want 0000", bus.ch_rsp_valid); else n_pass++;
    step();
    n_chk++; if (bus.wr_en !== 1'b0) $display("FAIL wr_strobe_len got %b want 0", bus.wr_en); else n_pass++;
    n_chk++; if (bus.ch_rsp_valid !== 4'b0100) $display("FAIL wr_rsp got %b want 0100", bus.ch_rsp_valid); else n_pass++;
    step();
    n_chk++; if (bus.ch_rsp_valid !== 4'b0000) $display("FAIL wr_rsp_len got %b want 0000", bus.ch_rsp_valid); else n_pass++;
    n_chk++; if (rd_cnt !== rd0) $display("FAIL wr_no_rd got %0d rd cycles want 0", rd_cnt - rd0); else n_pass++;
  endtask

  task automatic test_read();
    int g;
    a_arr[1] = 32'h20; wr = 4'b0000; valid = 4'b0010;
    wait_grant(g);
    n_chk++; if (g !== 1) $display("FAIL rd_grant got %0d want 1", g); else n_pass++;
    step(); valid = 4'b0000;
    n_chk++; if ({bus.wr_en, bus.rd_en} !== 2'b01) $display("FAIL rd_strobe got %b want 01", {bus.wr_en, bus.rd_en}); else n_pass++;
    n_chk++; if (bus.addr !== 32'h20) $display("FAIL rd_addr got %h want 20", bus.addr); else n_pass++;
    n_chk++; if (bus.wdata !== 32'h0) $display("FAIL rd_wdata got %h want 0", bus.wdata); else n_pass++;
    step();
    n_chk++; if ({bus.rd_en, bus.ch_rsp_valid} !== 5'b0) $display("FAIL rd_a2 got %b want 00000", {bus.rd_en, bus.ch_rsp_valid}); else n_pass++;
    step(); bus.rdata = 32'h12345678;
    n_chk++; if (bus.ch_rsp_valid !== 4'b0000) $display("FAIL rd_rsp_early got %b want 0000", bus.ch_rsp_valid); else n_pass++;
    step(); bus.rdata = RD_IDLE;
    n_chk++; if (bus.ch_rsp_valid !== 4'b0010) $display("FAIL rd_rsp got %b want 0010", bus.ch_rsp_valid); else n_pass++;
    n_chk++; if (bus.ch_rdata !== 32'h12345678) $display("FAIL rd_data got %h want 12345678", bus.ch_rdata); else n_pass++;
    step();
    n_chk++; if (bus.ch_rdata !== 32'h12345678) $display("FAIL rd_data_hold got %h want 12345678", bus.ch_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int g;
    int tot0 = rsp_sum();
    a_arr[1] = 32'h30; wr = 4'b0000; valid = 4'b0010;
    wait_grant(g);
    n_chk++; if (g !== 1) $display("FAIL rst_mid_grant got %0d want 1", g); else n_pass++;
    step(); valid = 4'b0000;
    n_chk++; if (bus.rd_en !== 1'b1) $display("FAIL rst_mid_rd got %b want 1", bus.rd_en); else n_pass++;
    step(); rst = 1'b1;
    step();
    n_chk++; if ({bus.wr_en, bus.rd_en, bus.ch_rsp_valid} !== 6'b0) $display("FAIL rst_mid_ctl got %b want 0", {bus.wr_en, bus.rd_en, bus.ch_rsp_valid}); else n_pass++;
    n_chk++; if ({bus.addr, bus.wdata, bus.ch_rdata} !== 96'h0) $display("FAIL rst_mid_data got %h want 0", {bus.addr, bus.wdata, bus.ch_rdata}); else n_pass++;
    rst = 1'b0;
    repeat (4) step();
    n_chk++; if (rsp_sum() !== tot0) $display("FAIL rst_mid_no_rsp got %0d rsps want 0", rsp_sum() - tot0); else n_pass++;
  endtask

  task automatic test_rr();
    int g;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    int base [4];
    for (int i = 0; i < 4; i++) begin
      base[i] = rsp_tot[i];
      a_arr[i] = 32'h100 + i;
      d_arr[i] = 32'hA000 + i;
    end
    wr = 4'b1111; valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      n_chk++; if (g !== exp_g[k]) $display("FAIL rr_grant%0d got %0d want %0d", k, g, exp_g[k]); else n_pass++;
      step();
      n_chk++; if (bus.addr !== 32'h100 + exp_g[k]) $display("FAIL rr_addr%0d got %h want %h", k, bus.addr, 32'h100 + exp_g[k]); else n_pass++;
    end
    valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (rsp_tot[i] - base[i] !== 1) $display("FAIL rr_rsp_ch%0d got %0d want 1", i, rsp_tot[i] - base[i]); else n_pass++;
    end
    step(); step();
  endtask

  task automatic test_prio();
    int g;
`ifdef DMA_ARB_PRIO_EN
    int exp_g [4] = '{0, 0, 0, 3};
`else
    int exp_g [4] = '{3, 0, 3, 3};
`endif
    wr = 4'b1111; valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      n_chk++; if (g !== exp_g[k]) $display("FAIL prio_grant%0d got %0d want %0d", k, g, exp_g[k]); else n_pass++;
      step();
      if (k == 2) valid = 4'b1000;
    end
    valid = 4'b0000;
    step(); step();
  endtask

  task automatic test_withdraw();
    int g;
    int wr0 = wr_cnt;
    int rd0 = rd_cnt;
    a_arr[0] = 32'h400; a_arr[1] = 32'h111; a_arr[2] = 32'h222;
    wr = 4'b0111; valid = 4'b0001;
    wait_grant(g);
    n_chk++; if (g !== 0) $display("FAIL wd_grant0 got %0d want 0", g); else n_pass++;
    step(); valid = 4'b0110; #1;
    n_chk++; if (bus.ch_ready !== 4'b0000) $display("FAIL wd_ready_issue got %b want 0000", bus.ch_ready); else n_pass++;
    step(); valid = 4'b0100; #1;
    n_chk++; if (bus.ch_ready !== 4'b0000) $display("FAIL wd_ready_resp got %b want 0000", bus.ch_ready); else n_pass++;
    n_chk++; if (bus.ch_rsp_valid !== 4'b0001) $display("FAIL wd_rsp0 got %b want 0001", bus.ch_rsp_valid); else n_pass++;
    step(); #1;
    n_chk++; if (bus.ch_ready !== 4'b0100) $display("FAIL wd_ready2 got %b want 0100", bus.ch_ready); else n_pass++;
    step(); valid = 4'b0000;
    n_chk++; if ({bus.wr_en, bus.addr} !== {1'b1, 32'h222}) $display("FAIL wd_bus got %b/%h want 1/222", bus.wr_en, bus.addr); else n_pass++;
    step();
    n_chk++; if (bus.ch_rsp_valid !== 4'b0100) $display("FAIL wd_rsp2 got %b want 0100", bus.ch_rsp_valid); else n_pass++;
    step();
    n_chk++; if ((wr_cnt - wr0 !== 2) || (rd_cnt !== rd0)) $display("FAIL wd_bus_count got wr %0d rd %0d want wr 2 rd 0", wr_cnt - wr0, rd_cnt - rd0); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 32'h0;
      d_arr[i] = 32'h0;
      rsp_tot[i] = 0;
    end
    bus.rdata = RD_IDLE;
    test_reset();
    test_write();
    test_read();
    test_reset_mid();
    test_rr();
    test_prio();
    test_withdraw();
    n_chk++; if (strobe_viol !== 0) $display("FAIL strobe_gap got %0d back-to-back strobes want 0", strobe_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
